// File: rtl/mem_sram_bridge_pkg.sv
// Shared types and constants for the MEM-stage SRAM-like data bus bridge.
package mem_sram_bridge_pkg;

    localparam int unsigned CPU_ADDR_W = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STRB_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [CPU_ADDR_W-1:0] KSEG_MASK = 32'h1FFF_FFFF;

    // kseg0/kseg1 occupy 0x8000_0000..0xBFFF_FFFF
    function automatic logic is_kseg01(input logic [CPU_ADDR_W-1:0] addr);
        return addr[31:30] == 2'b10;
    endfunction

endpackage

// File: rtl/mem_sram_bridge_if.sv
// SRAM-like split-transaction data bus (req/addr_ok, then data_ok).
interface mem_sram_bridge_if
    import mem_sram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic                data_req;
    logic                data_wr;
    logic [1:0]          data_size;
    logic [STRB_W-1:0]   data_wstrb;
    logic [ADDR_W-1:0]   data_addr;
    logic [DATA_W-1:0]   data_wdata;
    logic                data_addr_ok;
    logic                data_data_ok;
    logic [DATA_W-1:0]   data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_addr_map.sv
// Combinational virtual-to-physical map: kseg0/kseg1 fold onto the low 512 MB.
// Only present when MEM_BRIDGE_KSEG_MAP_EN is defined.
`ifdef MEM_BRIDGE_KSEG_MAP_EN
module mem_addr_map
    import mem_sram_bridge_pkg::*;
(
    input  logic [CPU_ADDR_W-1:0] vaddr,
    output logic [CPU_ADDR_W-1:0] paddr
);
    assign paddr = is_kseg01(vaddr) ? (vaddr & KSEG_MASK) : vaddr;
endmodule
`endif

// File: rtl/mem_sram_bridge.sv
// MEM-stage to SRAM-like data bus bridge; stalls the pipe until data_ok.
// Optional MEM_BRIDGE_KSEG_MAP_EN maps kseg0/kseg1 addresses to physical.
module mem_sram_bridge
    import mem_sram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_req,
    input  logic                   mem_wr,
    input  logic [STRB_W-1:0]      mem_sel,
    input  logic [1:0]             mem_size,
    input  logic [CPU_ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]      mem_wdata,
    input  logic [31:0]            mem_excepttype,
    input  logic                   sc_failed,
    input  logic                   flush,
    input  logic                   pipe_go,
    output logic [DATA_W-1:0]      mem_rdata,
    output logic                   mem_stall,
    mem_sram_bridge_if.master      bus
);
    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   go;
    logic [CPU_ADDR_W-1:0]  phys_addr;

`ifdef MEM_BRIDGE_KSEG_MAP_EN
    mem_addr_map u_addr_map (
        .vaddr (mem_addr),
        .paddr (phys_addr)
    );
`else
    assign phys_addr = mem_addr;
`endif

    // Killed accesses (exception, flush, failed SC) never reach the bus
    assign go = mem_req & ~flush & (mem_excepttype == 32'd0) & ~(mem_wr & sc_failed);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rdata_d      = rdata_q;
        mem_stall    = 1'b0;
        bus.data_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.data_req = go;
                mem_stall    = go;
                if (go && bus.data_addr_ok) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                mem_stall = 1'b1;
                if (bus.data_data_ok) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (!mem_wr) rdata_d = bus.data_rdata;
                        state_d = ST_DONE;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (pipe_go || flush) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                // in-flight transfer cannot be cancelled; swallow its data_ok
                mem_stall = mem_req;
                if (bus.data_data_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            mem_stall    = 1'b0;
            bus.data_req = 1'b0;
        end
    end

    assign bus.data_wr    = mem_wr;
    assign bus.data_size  = mem_size;
    assign bus.data_wstrb = mem_wr ? mem_sel : '0;
    assign bus.data_addr  = phys_addr[ADDR_W-1:0];
    assign bus.data_wdata = mem_wdata;
    assign mem_rdata      = rdata_q;

endmodule
